// File: rtl/piho_pkg.sv
// Shared types and constants for the PIHO run controller.
package piho_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RESET,
    RUN,
    SETTLE,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam int          SEED_WORDS = 15;
  localparam int          SEED_BITS  = 480;

  // An all-zero Galois LFSR is stuck forever, so zero is mapped to 1.
  function automatic logic [31:0] lfsr_nonzero(input logic [31:0] value);
    return (value == 32'h0) ? 32'h1 : value;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] state);
    logic [31:0] shifted;
    shifted = state >> 1;
    return lfsr_nonzero(state[0] ? (shifted ^ LFSR_TAPS) : shifted);
  endfunction

endpackage

// File: rtl/piho_seed_lfsr.sv
// 32-bit Galois LFSR seed source; word is the state the next advance will produce.
module piho_seed_lfsr
  import piho_pkg::*;
#(
  parameter logic [31:0] SEED_INIT = 32'h1D87_2B41
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        advance,
  output logic [31:0] word
);

  logic [31:0] state;

  assign word = lfsr_step(state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= lfsr_nonzero(SEED_INIT);
    end else if (load) begin
      state <= lfsr_nonzero(load_value);
    end else if (advance) begin
      state <= word;
    end
  end

endmodule

// File: rtl/piho_run_ctrl.sv
// Host-side run controller for the 16-unit PIHO array: seeds, resets, runs and returns results.
// Optional RUN-state timeout is enabled with PIHO_CTRL_TIMEOUT_EN.
module piho_run_ctrl
  import piho_pkg::*;
#(
  parameter logic [31:0] SEED_INIT      = 32'h1D87_2B41,
  parameter int          RST_CYCLES     = 16,
  parameter int          SETTLE_CYCLES  = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  cfg_conf,
  input  logic [31:0]  cfg_dump,
  output logic [239:0] seed,
  output logic [239:0] seed2,
  output logic [31:0]  MCNconf,
  output logic [31:0]  MCNdump,
  output logic         piho_rst,
  input  logic         finish,
  input  logic [63:0]  x2sumall,
  input  logic [31:0]  looptimes,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [63:0]  res_x2sum,
  output logic [31:0]  res_loops,
  output logic         res_timeout
);

  state_t               state;
  logic [7:0]           cnt;
  logic                 armed;
  logic [SEED_BITS-1:0] seed_all;
  logic [31:0]          lfsr_word;

  assign seed  = seed_all[239:0];
  assign seed2 = seed_all[SEED_BITS-1:240];

  piho_seed_lfsr #(
    .SEED_INIT(SEED_INIT)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_value(SEED_INIT),
    .advance   (state == SEED),
    .word      (lfsr_word)
  );

`ifdef PIHO_CTRL_TIMEOUT_EN
  logic [31:0] tcnt;
`else
  assign res_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      armed     <= 1'b0;
      seed_all  <= '0;
      MCNconf   <= 32'd0;
      MCNdump   <= 32'd0;
      piho_rst  <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_x2sum <= 64'd0;
      res_loops <= 32'd0;
`ifdef PIHO_CTRL_TIMEOUT_EN
      res_timeout <= 1'b0;
      tcnt        <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            MCNconf <= cfg_conf;
            MCNdump <= cfg_dump;
            busy    <= 1'b1;
            cnt     <= 8'd0;
            state   <= SEED;
          end
        end
        SEED: begin
          seed_all[{cnt[3:0], 5'd0} +: 32] <= lfsr_word;
          if (cnt == 8'(SEED_WORDS - 1)) begin
            cnt   <= 8'd0;
            state <= RESET;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // cnt reaches RST_CYCLES on the edge that releases the array.
        RESET: begin
          armed <= 1'b0;
`ifdef PIHO_CTRL_TIMEOUT_EN
          tcnt  <= 32'd0;
`endif
          if (cnt == 8'(RST_CYCLES)) begin
            piho_rst <= 1'b0;
            cnt      <= 8'd0;
            state    <= RUN;
          end else begin
            piho_rst <= 1'b1;
            cnt      <= cnt + 8'd1;
          end
        end
        RUN: begin
          if (!finish) begin
            armed <= 1'b1;
          end
          if (finish && armed) begin
            cnt   <= 8'd0;
            state <= SETTLE;
          end
`ifdef PIHO_CTRL_TIMEOUT_EN
          else if (tcnt == TIMEOUT_CYCLES - 32'd1) begin
            res_x2sum   <= x2sumall;
            res_loops   <= looptimes;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= DONE;
          end
          tcnt <= tcnt + 32'd1;
`endif
        end
        SETTLE: begin
          if (cnt == 8'(SETTLE_CYCLES - 1)) begin
            res_x2sum <= x2sumall;
            res_loops <= looptimes;
`ifdef PIHO_CTRL_TIMEOUT_EN
            res_timeout <= 1'b0;
`endif
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piho_run_ctrl.sv
// Directed testbench for piho_run_ctrl: table-driven runs plus hand-written corner sequences.
// Define PIHO_CTRL_TIMEOUT_EN to also exercise the RUN timeout.
module tb_piho_run_ctrl;

  localparam logic [31:0] TB_SEED_INIT = 32'h1D87_2B41;
  localparam logic [31:0] TB_TAPS      = 32'h8020_0003;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  cfgConf;
  logic [31:0]  cfgDump;
  logic [239:0] seed;
  logic [239:0] seed2;
  logic [31:0]  mcnConf;
  logic [31:0]  mcnDump;
  logic         pihoRst;
  logic         finish;
  logic [63:0]  x2sumall;
  logic [31:0]  looptimes;
  logic         busy;
  logic         resValid;
  logic         resReady;
  logic [63:0]  resX2sum;
  logic [31:0]  resLoops;
  logic         resTimeout;

  int checks;
  int errors;
  logic [31:0] refLfsr;
  logic        prst [0:32];

  typedef struct {
    logic [31:0] conf;
    logic [31:0] dump;
    int          stale;
    int          low;
    logic [63:0] x2;
    logic [31:0] loops;
    logic [31:0] expConf;
    logic [31:0] expDump;
    logic [63:0] expX2;
    logic [31:0] expLoops;
    int          expLat;
  } vec_t;

  vec_t vecs [3];

  piho_run_ctrl #(
    .SEED_INIT     (TB_SEED_INIT),
    .RST_CYCLES    (16),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_conf   (cfgConf),
    .cfg_dump   (cfgDump),
    .seed       (seed),
    .seed2      (seed2),
    .MCNconf    (mcnConf),
    .MCNdump    (mcnDump),
    .piho_rst   (pihoRst),
    .finish     (finish),
    .x2sumall   (x2sumall),
    .looptimes  (looptimes),
    .busy       (busy),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .res_x2sum  (resX2sum),
    .res_loops  (resLoops),
    .res_timeout(resTimeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish within 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] refStep(input logic [31:0] s);
    logic [31:0] n;
    n = s[0] ? ((s >> 1) ^ TB_TAPS) : (s >> 1);
    return (n == 32'h0) ? 32'h1 : n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitValid(input int maxCycles, output int lat);
    lat = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clk);
      if (resValid) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  // Accepts a run and checks config latch, seed words and the array reset window.
  task automatic runStart(input logic [31:0] conf, input logic [31:0] dump,
                          input logic [31:0] expConf, input logic [31:0] expDump,
                          input bit firstAfterReset);
    logic [479:0] seedAll;
    @(negedge clk);
    start   = 1'b1;
    cfgConf = conf;
    cfgDump = dump;
    @(negedge clk);
    start   = 1'b0;
    cfgConf = 32'hDEAD_BEEF;
    cfgDump = 32'hCAFE_F00D;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("MCNconf", mcnConf, expConf);
    checkOutput("MCNdump", mcnDump, expDump);
    prst[0] = pihoRst;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      prst[k] = pihoRst;
      if (k == 15) begin
        seedAll = {seed2, seed};
        for (int w = 0; w < 15; w++) begin
          refLfsr = refStep(refLfsr);
          checkOutput($sformatf("seed_word%0d", w), seedAll[w*32 +: 32], refLfsr);
        end
      end
    end
    checkOutput("piho_rst_before_fall", prst[31], 1);
    checkOutput("piho_rst_fall", prst[32], 0);
    if (!firstAfterReset) begin
      int highs;
      highs = 0;
      for (int k = 0; k <= 32; k++) highs += prst[k] ? 1 : 0;
      checkOutput("piho_rst_rise", {prst[15], prst[16]}, 2'b01);
      checkOutput("piho_rst_high_cycles", highs, 16);
    end
  endtask

  // Runs one table vector through completion with res_ready already high.
  task automatic applyStimulus(input vec_t v, input bit firstAfterReset);
    int lat;
    finish    = (v.stale > 0);
    resReady  = 1'b1;
    runStart(v.conf, v.dump, v.expConf, v.expDump, firstAfterReset);
    if (v.stale > 0) begin
      repeat (v.stale) @(negedge clk);
      checkOutput("stale_finish_no_valid", resValid, 0);
      checkOutput("stale_finish_busy", busy, 1);
    end
    finish = 1'b0;
    repeat (v.low) @(negedge clk);
    finish    = 1'b1;
    x2sumall  = v.x2;
    looptimes = v.loops;
    waitValid(40, lat);
    checkOutput("completion_latency", lat, v.expLat);
    checkOutput("res_x2sum", resX2sum, v.expX2);
    checkOutput("res_loops", resLoops, v.expLoops);
    checkOutput("res_timeout", resTimeout, 0);
    @(negedge clk);
    checkOutput("valid_one_cycle", resValid, 0);
    checkOutput("busy_after_transfer", busy, 0);
    finish = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] heldX2;
    checks    = 0;
    errors    = 0;
    start     = 1'b0;
    cfgConf   = 32'd0;
    cfgDump   = 32'd0;
    finish    = 1'b0;
    x2sumall  = 64'd0;
    looptimes = 32'd0;
    resReady  = 1'b0;
    refLfsr   = TB_SEED_INIT;

    vecs[0] = '{conf: 32'd1000, dump: 32'd100, stale: 0, low: 50,
                x2: 64'h0000_0012_3456_789A, loops: 32'd1000,
                expConf: 32'd1000, expDump: 32'd100,
                expX2: 64'h0000_0012_3456_789A, expLoops: 32'd1000, expLat: 4};
    vecs[1] = '{conf: 32'hFFFF_FFFF, dump: 32'd0, stale: 0, low: 1,
                x2: 64'hFFFF_FFFF_FFFF_FFFF, loops: 32'hFFFF_FFFF,
                expConf: 32'hFFFF_FFFF, expDump: 32'd0,
                expX2: 64'hFFFF_FFFF_FFFF_FFFF, expLoops: 32'hFFFF_FFFF, expLat: 4};
    vecs[2] = '{conf: 32'd500, dump: 32'd50, stale: 20, low: 3,
                x2: 64'h0000_0000_0000_0001, loops: 32'd7,
                expConf: 32'd500, expDump: 32'd50,
                expX2: 64'h0000_0000_0000_0001, expLoops: 32'd7, expLat: 4};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_piho_rst", pihoRst, 1);
    checkOutput("reset_res_valid", resValid, 0);
    checkOutput("reset_MCNconf", mcnConf, 0);
    checkOutput("reset_seed", seed[63:0], 0);
    checkOutput("reset_res_timeout", resTimeout, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_piho_rst_held", pihoRst, 1);

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i == 0);

    // Host stalls in DONE; a start pulse there and on the transfer edge is ignored.
    resReady = 1'b0;
    runStart(32'd7, 32'd3, 32'd7, 32'd3, 1'b0);
    finish = 1'b0;
    repeat (5) @(negedge clk);
    finish    = 1'b1;
    x2sumall  = 64'hA5A5_5A5A_0F0F_F0F0;
    looptimes = 32'd1234;
    waitValid(40, lat);
    checkOutput("hold_latency", lat, 4);
    heldX2    = 64'hA5A5_5A5A_0F0F_F0F0;
    x2sumall  = 64'h1111_2222_3333_4444;
    looptimes = 32'd9;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
      checkOutput("hold_valid", resValid, 1);
      checkOutput("hold_x2sum", resX2sum, heldX2);
    end
    checkOutput("hold_loops", resLoops, 32'd1234);
    checkOutput("hold_MCNconf", mcnConf, 32'd7);
    resReady = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_valid_drop", resValid, 0);
    checkOutput("hold_busy_drop", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("start_on_transfer_ignored", busy, 0);
    finish = 1'b0;

`ifdef PIHO_CTRL_TIMEOUT_EN
    runStart(32'd11, 32'd1, 32'd11, 32'd1, 1'b0);
    finish    = 1'b0;
    x2sumall  = 64'h77;
    looptimes = 32'd55;
    waitValid(200, lat);
    checkOutput("timeout_latency", lat, 99);
    checkOutput("timeout_flag", resTimeout, 1);
    checkOutput("timeout_x2sum", resX2sum, 64'h77);
    checkOutput("timeout_loops", resLoops, 32'd55);
    @(negedge clk);
    checkOutput("timeout_transfer", resValid, 0);
`endif

    // Asynchronous reset in the middle of RUN.
    runStart(32'd21, 32'd2, 32'd21, 32'd2, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrun_piho_rst", pihoRst, 1);
    checkOutput("midrun_res_valid", resValid, 0);
    checkOutput("midrun_busy", busy, 0);
    checkOutput("midrun_MCNconf", mcnConf, 0);
    @(negedge clk);
    rst     = 1'b1;
    refLfsr = TB_SEED_INIT;
    applyStimulus(vecs[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piho_run_ctrl.md
# piho_run_ctrl

Run controller driving the 16-unit path-integral harmonic-oscillator array (`piho_top_real`) from the host side. It accepts a run request, generates the 480 bits of per-unit LFSR seeds, holds the array in reset, and starts the run. It waits for `finish`, lets the three-stage `x2sumall` adder tree settle, then returns `x2sumall` and `looptimes` to the host over a valid/ready handshake.

## Interface
- `SEED_INIT`, 32'h1D87_2B41, LFSR load value for the first run; zero is replaced by 32'h1
- `RST_CYCLES`, 16, cycles `piho_rst` is held high per run (range 2..255)
- `SETTLE_CYCLES`, 4, cycles from `finish` to result capture (minimum 3, which is the adder-tree depth)
- `TIMEOUT_CYCLES`, 32'hFFFF_FFFF, RUN-state cycle limit (used only with the timeout feature)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  run request pulse; accepted only in IDLE
- `cfg_conf`  in  32  total configurations, sampled when `start` is accepted
- `cfg_dump`  in  32  warm-up configurations to discard, sampled when `start` is accepted
- `seed`  out  240  seed bus for units 1–8
- `seed2`  out  240  seed bus for units 9–16
- `MCNconf`  out  32  latched `cfg_conf`
- `MCNdump`  out  32  latched `cfg_dump`
- `piho_rst`  out  1  active-high reset to the array
- `finish`  in  1  array completion level
- `x2sumall`  in  64  array result
- `looptimes`  in  32  array loop count
- `busy`  out  1  high in every state except IDLE
- `res_valid`  out  1  result available
- `res_ready`  in  1  host accepts the result
- `res_x2sum`  out  64  captured `x2sumall`
- `res_loops`  out  32  captured `looptimes`
- `res_timeout`  out  1  result was produced by a timeout, not by `finish`

## Operation
- States: IDLE → SEED → RESET → RUN → SETTLE → DONE → IDLE.
- With the timeout feature, RUN → DONE is also possible on timeout.
- IDLE
  - `start` high: latch `cfg_conf`/`cfg_dump` into `MCNconf`/`MCNdump`; go to SEED.
  - `start` is ignored in every other state.
- SEED: 15 cycles.
  - Each cycle the 32-bit Galois LFSR (taps 32'h8020_0003) advances one step.
  - Its new state is written into word k (k = 0..14) of the concatenation {seed2, seed}. Word 0 is `seed[31:0]`; word 14 is `seed2[239:208]`.
  - The LFSR state persists across runs, so consecutive runs get different seeds.
- RESET: `piho_rst` is high for `RST_CYCLES` cycles, then → RUN.
- RUN: `piho_rst` low.
  - An arm flag sets once `finish` is sampled low.
  - `finish` high while armed → SETTLE. A stale high `finish` before the array clears is never taken as completion.
- SETTLE: count `SETTLE_CYCLES` cycles. On the last cycle, capture `x2sumall`→`res_x2sum` and `looptimes`→`res_loops`, clear `res_timeout`, → DONE.
- DONE: `res_valid` high; result outputs stable until `res_valid && res_ready`, then → IDLE in the same edge.
- `seed`/`seed2`/`MCNconf`/`MCNdump` hold their values from SEED until the next accepted `start`.
- Reset values (async, `rst` low): state IDLE, LFSR = `SEED_INIT` (zero → 1), `piho_rst` = 1, all other outputs 0. `piho_rst` = 1 keeps the array parked while idle after reset.
- `piho_rst` returns to 0 only in RUN, and stays 0 through SETTLE/DONE/IDLE until the next RESET state.
- Reset asserted mid-run: the controller returns to IDLE, any pending result is discarded, and the array is re-held in reset.

## Timing
- `start` accepted at edge T.
  - SEED occupies T+1..T+15.
  - `piho_rst` rises at T+16 and falls at T+16+`RST_CYCLES`.
- Completion latency: `finish` (armed) sampled high at edge F → `res_valid` high after edge F+`SETTLE_CYCLES`.
- Handshake: valid/ready, with no combinational path from `res_ready` to any output.
  - `res_ready` high already when `res_valid` rises → transfer on that edge; `res_valid` is high for exactly one cycle.
- `start` in the same cycle as the DONE→IDLE transfer is ignored; the next run needs a new `start` while in IDLE.
- `busy` is registered: high from T+1 until the transfer edge.

## Configuration
- `PIHO_CTRL_TIMEOUT_EN` defined:
  - A 32-bit counter runs in RUN.
  - Reaching `TIMEOUT_CYCLES` without completion → DONE with `res_timeout` = 1 and `res_x2sum`/`res_loops` captured from the current inputs.
- `PIHO_CTRL_TIMEOUT_EN` undefined:
  - No counter; RUN waits on `finish` indefinitely.
  - `res_timeout` is tied to 0.

## Structure
- Shared package `piho_pkg`: state enum, LFSR tap constant, `SEED_WORDS` = 15, `SEED_BITS` = 480.
- Sub-module `piho_seed_lfsr`: 32-bit Galois LFSR with load/advance, nonzero guard and output word; instantiated once.
- FSM, counters and capture registers live in the top.

## Test plan
- Reset release, then `start` with `cfg_conf`=1000 and `cfg_dump`=100 → `MCNconf`=1000, `MCNdump`=100; 15 seed words equal the reference LFSR sequence from 32'h1D87_2B41; `piho_rst` high exactly 16 cycles.
- Model array: `finish` low for 50 cycles then high, `x2sumall`=64'h0000_0012_3456_789A, `looptimes`=1000 → `res_valid` rises 4 cycles after `finish`, with these values and `res_timeout`=0.
- `finish` held high from reset through RESET → no completion until `finish` drops and rises again.
- `res_ready` low for 10 cycles in DONE → outputs stable; `res_valid` drops the cycle after the `res_ready` handshake. A `start` pulse during DONE is ignored.
- Two back-to-back runs → second run's seed words continue the LFSR sequence (word 0 of run 2 = 16th LFSR state).
- With `PIHO_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, `finish` never rises → `res_valid` with `res_timeout`=1. Separately, async `rst` low mid-RUN → IDLE, `piho_rst`=1, `res_valid`=0.
